// File: rtl/cache_pkg.sv
// Shared types and default widths for the blocking write-through cache controller.
package cache_pkg;

  localparam int unsigned AddressWidthDefault = 32;
  localparam int unsigned DataWidthDefault    = 32;
  localparam int unsigned CntWidthDefault     = 16;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    RESP,
    WRITE
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_ctrl.sv
// Blocking cache controller: zero-latency load hits, refill on load miss,
// write-through stores without allocation, saturating hit/miss statistics.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = AddressWidthDefault,
  parameter int unsigned DATA_WIDTH    = DataWidthDefault,
  parameter int unsigned CNT_WIDTH     = CntWidthDefault
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wd,
  output logic                     cpu_stall,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  input  logic                     cache_hit,
  input  logic [DATA_WIDTH-1:0]    cache_rdata,
  output logic                     fill_en,
  output logic [ADDRESS_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0]    fill_data,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic                     mem_ready,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [CNT_WIDTH-1:0]     hit_count,
  output logic [CNT_WIDTH-1:0]     miss_count
);

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wd_q;
  logic                     hit_q;
  logic [DATA_WIDTH-1:0]    refill_q;
  logic                     hit_inc;
  logic                     miss_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wd_q     <= '0;
      hit_q    <= 1'b0;
      refill_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            addr_q <= cpu_addr;
            if (cpu_we) begin
              wd_q    <= cpu_wd;
              hit_q   <= cache_hit;
              state_q <= WRITE;
            end else if (!cache_hit) begin
              state_q <= REFILL;
            end
          end
        end
        REFILL: begin
          if (mem_ready) begin
            refill_q <= mem_rdata;
            state_q  <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        WRITE:   if (mem_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode from the registered state so reset drops mem_req without a clock.
  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = cache_rdata;
    fill_en   = 1'b0;
    fill_addr = addr_q;
    fill_data = mem_rdata;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wd    = wd_q;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_stall = cpu_req & (cpu_we | ~cache_hit);
        hit_inc   = cpu_req & ~cpu_we & cache_hit;
        miss_inc  = cpu_req & ~cpu_we & ~cache_hit;
      end
      REFILL: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        fill_en   = mem_ready;
      end
      RESP: begin
        cpu_rdata = refill_q;
      end
      WRITE: begin
        cpu_stall = ~mem_ready;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        fill_en   = mem_ready & hit_q;
        fill_data = wd_q;
      end
      default: ;
    endcase
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_hit_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (hit_inc),
    .count(hit_count)
  );

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_miss_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (miss_inc),
    .count(miss_count)
  );

endmodule
